// File: rtl/tt_vpu_sched_pkg.sv
// Shared types and helpers for the OVI issue scheduler and its completion ROB.
package tt_vpu_sched_pkg;

   // Scoreboard-id width carried by every ROB entry.
   localparam int SCHED_SB_W = 5;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } sched_state_e;

   typedef struct packed {
      logic [SCHED_SB_W-1:0] sb_id;
      logic                  done;
      logic                  valid;
   } rob_entry_t;

   // Bits needed to hold the values 0..n inclusive.
   function automatic int clog2p1(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/tt_vpu_cpl_rob.sv
// Completion reorder buffer: allocates entries in dispatch order, marks them
// done by sb_id lookup in any order, and retires the head when it is done.
// ROB_DEPTH must be a power of two; the extra pointer bit is the wrap phase.
module tt_vpu_cpl_rob
   import tt_vpu_sched_pkg::*;
#(
   parameter int ROB_DEPTH = 8,
   parameter int SB_W      = SCHED_SB_W
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_alloc,
   input  logic [SB_W-1:0] i_alloc_sb_id,
   input  logic            i_done_valid,
   input  logic [SB_W-1:0] i_done_sb_id,
   output logic            o_full,
   output logic            o_head_pop,
   output logic [SB_W-1:0] o_head_sb_id,
   output logic            o_done_miss
);

   localparam int IW = $clog2(ROB_DEPTH);
   localparam int PW = IW + 1;

   rob_entry_t              r_rob [ROB_DEPTH];
   logic [PW-1:0]           r_wr_ptr;
   logic [PW-1:0]           r_rd_ptr;

   logic [IW-1:0]           w_wr_idx;
   logic [IW-1:0]           w_rd_idx;
   rob_entry_t              w_head;
   logic [ROB_DEPTH-1:0]    w_hit;
   logic                    w_alloc_hit;

   assign w_wr_idx     = r_wr_ptr[IW-1:0];
   assign w_rd_idx     = r_rd_ptr[IW-1:0];
   assign w_head       = r_rob[w_rd_idx];
   assign o_full       = (w_wr_idx == w_rd_idx) && (r_wr_ptr[IW] != r_rd_ptr[IW]);
   assign o_head_sb_id = w_head.sb_id;

   // Done lookup against every resident entry.
   always_comb begin
      w_hit = '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
         w_hit[i] = r_rob[i].valid && (r_rob[i].sb_id == i_done_sb_id);
      end
   end

   // A done report may also target the entry being written this cycle.
   assign w_alloc_hit = i_alloc && (i_alloc_sb_id == i_done_sb_id);

   // Head retires when already done or when its done report arrives now.
   assign o_head_pop  = w_head.valid &&
                        (w_head.done || (i_done_valid && w_hit[w_rd_idx]));

   assign o_done_miss = i_done_valid && (w_hit == '0) && !w_alloc_hit;

   // Entry storage, done marking, head retire and tail allocate.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < ROB_DEPTH; i++) begin
            r_rob[i].valid <= 1'b0;
            r_rob[i].done  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < ROB_DEPTH; i++) begin
            if (i_done_valid && w_hit[i]) begin
               r_rob[i].done <= 1'b1;
            end
         end
         if (o_head_pop) begin
            r_rob[w_rd_idx].valid <= 1'b0;
            r_rd_ptr              <= r_rd_ptr + PW'(1);
         end
         // Allocation is last so a full-ROB retire+refill of the same slot keeps the new entry.
         if (i_alloc) begin
            r_rob[w_wr_idx].sb_id <= i_alloc_sb_id;
            r_rob[w_wr_idx].done  <= i_done_valid && w_alloc_hit;
            r_rob[w_wr_idx].valid <= 1'b1;
            r_wr_ptr              <= r_wr_ptr + PW'(1);
         end
      end
   end

endmodule

// File: rtl/tt_vpu_issue_sched.sv
// OVI issue scheduler: grants the initial issue credits, returns credits for
// popped and killed entries, hands FIFO heads to the VPU and turns
// out-of-order VPU done reports into in-order OVI completions.
module tt_vpu_issue_sched
   import tt_vpu_sched_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int ROB_DEPTH  = 8,
   parameter int SB_W       = SCHED_SB_W
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_issue_valid,
   input  logic            i_dispatch_next_senior,
   input  logic            i_dispatch_kill,
   output logic            o_issue_credit,
   output logic            o_fifo_read_req,
   input  logic            i_fifo_read_valid,
   input  logic [SB_W-1:0] i_fifo_read_sb_id,
   input  logic            i_vpu_ready,
   output logic            o_vpu_inst_valid,
   output logic [SB_W-1:0] o_vpu_inst_sb_id,
   input  logic            i_vpu_done_valid,
   input  logic [SB_W-1:0] i_vpu_done_sb_id,
   output logic            o_completed_valid,
   output logic [SB_W-1:0] o_completed_sb_id,
   output logic            o_sched_err
);

   // Counter width and a wider scratch width so sums never wrap before checking.
   localparam int CW = clog2p1(FIFO_DEPTH);
   localparam int AW = CW + 2;

   sched_state_e    r_state;
   logic [CW-1:0]   r_init_cnt;
   logic [CW-1:0]   r_spec_cnt;
   logic [CW-1:0]   r_owed;
   logic [CW-1:0]   r_core_cred;
   logic            r_issue_credit;
   logic            r_completed_valid;
   logic [SB_W-1:0] r_completed_sb_id;
   logic            r_sched_err;

   logic            w_run;
   logic            w_rob_full;
   logic            w_rob_pop;
   logic [SB_W-1:0] w_rob_head_sb_id;
   logic            w_rob_miss;
   logic            w_read_req;
   logic            w_fire;
   logic            w_senior_ok;
   logic [AW-1:0]   w_spec_upd;
   logic [AW-1:0]   w_reclaim;
   logic [CW-1:0]   w_spec_next;
   logic [AW-1:0]   w_avail;
   logic            w_credit_run;
   logic [AW-1:0]   w_owed_raw;
   logic [CW-1:0]   w_owed_next;
   logic            w_owed_ovf;
   logic            w_cred_take;
   logic [AW-1:0]   w_cred_raw;
   logic [CW-1:0]   w_cred_next;
   logic            w_sched_err_set;

   // Clamp a scratch value into the 0..FIFO_DEPTH counter range.
   function automatic logic [CW-1:0] sat_cnt(input logic [AW-1:0] v);
      if (v > AW'(FIFO_DEPTH)) begin
         return CW'(FIFO_DEPTH);
      end
      return v[CW-1:0];
   endfunction

   tt_vpu_cpl_rob #(
      .ROB_DEPTH (ROB_DEPTH),
      .SB_W      (SB_W)
   ) u_rob (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_alloc       (w_fire),
      .i_alloc_sb_id (i_fifo_read_sb_id),
      .i_done_valid  (i_vpu_done_valid),
      .i_done_sb_id  (i_vpu_done_sb_id),
      .o_full        (w_rob_full),
      .o_head_pop    (w_rob_pop),
      .o_head_sb_id  (w_rob_head_sb_id),
      .o_done_miss   (w_rob_miss)
   );

   // A full ROB still accepts when its head retires in the same cycle.
   assign w_run      = (r_state == RUN);
   assign w_read_req = w_run && i_vpu_ready && (!w_rob_full || w_rob_pop);
   assign w_fire     = w_read_req && i_fifo_read_valid;

   assign o_fifo_read_req   = w_read_req;
   assign o_vpu_inst_valid  = w_fire;
   assign o_vpu_inst_sb_id  = i_fifo_read_sb_id;
   assign o_issue_credit    = r_issue_credit;
   assign o_completed_valid = r_completed_valid;
   assign o_completed_sb_id = r_completed_sb_id;
   assign o_sched_err       = r_sched_err;

   // Next-state arithmetic for speculative, owed and core-held credit counts.
   always_comb begin
      w_senior_ok  = i_dispatch_next_senior && ((r_spec_cnt != '0) || i_issue_valid);
      w_spec_upd   = AW'(r_spec_cnt) + AW'(i_issue_valid) - AW'(w_senior_ok);
      w_reclaim    = i_dispatch_kill ? w_spec_upd : '0;
      w_spec_next  = i_dispatch_kill ? '0 : sat_cnt(w_spec_upd);

      w_avail      = AW'(r_owed) + AW'(w_fire) + w_reclaim;
      w_credit_run = w_run && (w_avail != '0);
      w_owed_raw   = w_avail - AW'(w_credit_run);
      w_owed_next  = sat_cnt(w_owed_raw);
      w_owed_ovf   = (w_owed_raw > AW'(FIFO_DEPTH));

      // Core-held credits: every pulse adds one, every issue spends one.
      w_cred_take  = i_issue_valid && (r_core_cred != '0);
      w_cred_raw   = AW'(r_core_cred) + AW'(r_issue_credit) - AW'(w_cred_take);
      w_cred_next  = sat_cnt(w_cred_raw);

      w_sched_err_set = w_rob_miss ||
                        (i_issue_valid && (r_core_cred == '0)) ||
                        (i_dispatch_kill && i_issue_valid) ||
                        (i_dispatch_next_senior && (r_spec_cnt == '0) && !i_issue_valid) ||
                        w_owed_ovf;
   end

   // INIT/RUN sequencing, counters, registered credit/completion outputs and sticky error.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state           <= INIT;
         r_init_cnt        <= '0;
         r_spec_cnt        <= '0;
         r_owed            <= '0;
         r_core_cred       <= '0;
         r_issue_credit    <= 1'b0;
         r_completed_valid <= 1'b0;
         r_completed_sb_id <= '0;
         r_sched_err       <= 1'b0;
      end else begin
         case (r_state)
            INIT: begin
               r_issue_credit <= 1'b1;
               r_init_cnt     <= r_init_cnt + CW'(1);
               if (r_init_cnt == CW'(FIFO_DEPTH - 1)) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_issue_credit <= w_credit_run;
            end
            default: begin
               r_state        <= INIT;
               r_issue_credit <= 1'b0;
            end
         endcase
         r_spec_cnt        <= w_spec_next;
         r_owed            <= w_owed_next;
         r_core_cred       <= w_cred_next;
         r_completed_valid <= w_rob_pop;
         if (w_rob_pop) begin
            r_completed_sb_id <= w_rob_head_sb_id;
         end
         if (w_sched_err_set) begin
            r_sched_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tt_vpu_issue_sched.sv
// Directed bench for the OVI issue scheduler: init credits, dispatch,
// credit reclaim on kill, in-order completion, ROB full, errors and reset.
module tb_tt_vpu_issue_sched;

   logic       clk;
   logic       reset;
   logic       issue_valid;
   logic       next_senior;
   logic       kill;
   logic       issue_credit;
   logic       read_req;
   logic       read_valid;
   logic [4:0] read_sb_id;
   logic       vpu_ready;
   logic       inst_valid;
   logic [4:0] inst_sb_id;
   logic       done_valid;
   logic [4:0] done_sb_id;
   logic       cpl_valid;
   logic [4:0] cpl_sb_id;
   logic       sched_err;

   int n_checks;
   int n_fail;

   tt_vpu_issue_sched #(
      .FIFO_DEPTH (4),
      .ROB_DEPTH  (8),
      .SB_W       (5)
   ) dut (
      .i_clk                  (clk),
      .i_reset                (reset),
      .i_issue_valid          (issue_valid),
      .i_dispatch_next_senior (next_senior),
      .i_dispatch_kill        (kill),
      .o_issue_credit         (issue_credit),
      .o_fifo_read_req        (read_req),
      .i_fifo_read_valid      (read_valid),
      .i_fifo_read_sb_id      (read_sb_id),
      .i_vpu_ready            (vpu_ready),
      .o_vpu_inst_valid       (inst_valid),
      .o_vpu_inst_sb_id       (inst_sb_id),
      .i_vpu_done_valid       (done_valid),
      .i_vpu_done_sb_id       (done_sb_id),
      .o_completed_valid      (cpl_valid),
      .o_completed_sb_id      (cpl_sb_id),
      .o_sched_err            (sched_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and drop all one-cycle strobes.
   task automatic nxt();
      @(negedge clk);
      issue_valid = 1'b0;
      next_senior = 1'b0;
      kill        = 1'b0;
      read_valid  = 1'b0;
      read_sb_id  = 5'd0;
      done_valid  = 1'b0;
      done_sb_id  = 5'd0;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      reset       = 1'b1;
      vpu_ready   = 1'b0;
      issue_valid = 1'b0;
      next_senior = 1'b0;
      kill        = 1'b0;
      read_valid  = 1'b0;
      read_sb_id  = 5'd0;
      done_valid  = 1'b0;
      done_sb_id  = 5'd0;

      // Reset state
      repeat (3) nxt();
      #1;
      chk("rst_credit",   32'(issue_credit), 32'd0);
      chk("rst_read_req", 32'(read_req),     32'd0);
      chk("rst_inst",     32'(inst_valid),   32'd0);
      chk("rst_cpl",      32'(cpl_valid),    32'd0);
      chk("rst_err",      32'(sched_err),    32'd0);

      // INIT credit burst: four pulses, no FIFO reads while initialising
      nxt(); reset = 1'b0; vpu_ready = 1'b1; #1;
      chk("init_credit_c0", 32'(issue_credit), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         nxt(); #1;
         chk($sformatf("init_credit_c%0d", i), 32'(issue_credit), 32'd1);
         if (i < 4) chk($sformatf("init_read_req_c%0d", i), 32'(read_req), 32'd0);
      end
      nxt(); #1;
      chk("init_credit_c5", 32'(issue_credit), 32'd0);
      chk("run_read_req",   32'(read_req),     32'd1);

      // Issue + senior same cycle, head id 3 fires straight to the VPU
      nxt(); issue_valid = 1'b1; next_senior = 1'b1; read_valid = 1'b1; read_sb_id = 5'd3; #1;
      chk("disp3_valid",  32'(inst_valid),   32'd1);
      chk("disp3_id",     32'(inst_sb_id),   32'd3);
      chk("disp3_credit", 32'(issue_credit), 32'd0);
      nxt(); #1;
      chk("disp3_credit_next", 32'(issue_credit), 32'd1);
      nxt(); done_valid = 1'b1; done_sb_id = 5'd3; #1;
      chk("disp3_credit_off", 32'(issue_credit), 32'd0);
      chk("cpl3_early",       32'(cpl_valid),    32'd0);
      nxt(); #1;
      chk("cpl3_valid", 32'(cpl_valid), 32'd1);
      chk("cpl3_id",    32'(cpl_sb_id), 32'd3);
      nxt(); #1;
      chk("cpl3_off", 32'(cpl_valid), 32'd0);

      // Three issues, one senior, then kill together with the senior pop
      for (int i = 0; i < 3; i++) begin
         nxt(); issue_valid = 1'b1; #1;
      end
      nxt(); next_senior = 1'b1; #1;
      nxt(); kill = 1'b1; read_valid = 1'b1; read_sb_id = 5'd5; #1;
      chk("kill_pop_valid", 32'(inst_valid),   32'd1);
      chk("kill_pop_id",    32'(inst_sb_id),   32'd5);
      chk("kill_credit_c0", 32'(issue_credit), 32'd0);
      for (int i = 1; i <= 3; i++) begin
         nxt(); #1;
         chk($sformatf("kill_credit_c%0d", i), 32'(issue_credit), 32'd1);
      end
      nxt(); done_valid = 1'b1; done_sb_id = 5'd5; #1;
      chk("kill_credit_c4", 32'(issue_credit), 32'd0);
      nxt(); #1;
      chk("cpl5_valid", 32'(cpl_valid), 32'd1);
      chk("cpl5_id",    32'(cpl_sb_id), 32'd5);
      chk("no_err_yet", 32'(sched_err), 32'd0);

      // Dispatch 1,2,3; done in order 3,1,2; completions come out 1,2,3
      for (int i = 1; i <= 3; i++) begin
         nxt(); read_valid = 1'b1; read_sb_id = 5'(i); #1;
         chk($sformatf("ooo_disp%0d", i), 32'(inst_sb_id), 32'(i));
      end
      nxt(); done_valid = 1'b1; done_sb_id = 5'd3; #1;
      nxt(); done_valid = 1'b1; done_sb_id = 5'd1; #1;
      chk("ooo_cpl_none", 32'(cpl_valid), 32'd0);
      nxt(); done_valid = 1'b1; done_sb_id = 5'd2; #1;
      chk("ooo_cpl1_valid", 32'(cpl_valid), 32'd1);
      chk("ooo_cpl1_id",    32'(cpl_sb_id), 32'd1);
      nxt(); #1;
      chk("ooo_cpl2_valid", 32'(cpl_valid), 32'd1);
      chk("ooo_cpl2_id",    32'(cpl_sb_id), 32'd2);
      nxt(); #1;
      chk("ooo_cpl3_valid", 32'(cpl_valid), 32'd1);
      chk("ooo_cpl3_id",    32'(cpl_sb_id), 32'd3);
      nxt(); #1;
      chk("ooo_cpl_end", 32'(cpl_valid), 32'd0);

      // Fill all eight ROB entries with ids 10..17
      for (int i = 0; i < 8; i++) begin
         nxt(); read_valid = 1'b1; read_sb_id = 5'(10 + i); #1;
         chk($sformatf("fill_%0d", i), 32'(inst_valid), 32'd1);
      end
      nxt(); read_valid = 1'b1; read_sb_id = 5'd18; #1;
      chk("full_read_req", 32'(read_req),   32'd0);
      chk("full_inst",     32'(inst_valid), 32'd0);
      nxt(); read_valid = 1'b1; read_sb_id = 5'd18; done_valid = 1'b1; done_sb_id = 5'd10; #1;
      chk("full_pop_read_req", 32'(read_req),   32'd1);
      chk("full_pop_inst",     32'(inst_valid), 32'd1);
      chk("full_pop_id",       32'(inst_sb_id), 32'd18);
      nxt(); read_valid = 1'b1; read_sb_id = 5'd19; #1;
      chk("full_cpl_valid",  32'(cpl_valid), 32'd1);
      chk("full_cpl_id",     32'(cpl_sb_id), 32'd10);
      chk("full_again_req",  32'(read_req),  32'd0);

      // Done for an id that was never dispatched
      nxt(); done_valid = 1'b1; done_sb_id = 5'd9; #1;
      chk("miss_err_before", 32'(sched_err), 32'd0);
      nxt(); #1;
      chk("miss_err_set", 32'(sched_err), 32'd1);
      nxt(); #1;
      chk("miss_err_hold", 32'(sched_err), 32'd1);

      // Reset in the middle of traffic, then the INIT burst replays
      nxt(); reset = 1'b1; issue_valid = 1'b1; read_valid = 1'b1; read_sb_id = 5'd20; #1;
      nxt(); #1;
      chk("mid_rst_credit",   32'(issue_credit), 32'd0);
      chk("mid_rst_read_req", 32'(read_req),     32'd0);
      chk("mid_rst_inst",     32'(inst_valid),   32'd0);
      chk("mid_rst_cpl",      32'(cpl_valid),    32'd0);
      chk("mid_rst_err",      32'(sched_err),    32'd0);
      nxt(); reset = 1'b0; #1;
      chk("replay_credit_c0", 32'(issue_credit), 32'd0);
      for (int i = 1; i <= 4; i++) begin
         nxt(); #1;
         chk($sformatf("replay_credit_c%0d", i), 32'(issue_credit), 32'd1);
      end
      nxt(); #1;
      chk("replay_credit_c5", 32'(issue_credit), 32'd0);
      chk("replay_rob_empty", 32'(read_req),     32'd1);

      // Kill with nothing speculative is harmless
      nxt(); kill = 1'b1; #1;
      nxt(); #1;
      chk("idle_kill_credit", 32'(issue_credit), 32'd0);
      chk("idle_kill_err",    32'(sched_err),    32'd0);

      // Senior with nothing speculative is a protocol error
      nxt(); next_senior = 1'b1; #1;
      nxt(); #1;
      chk("bad_senior_err", 32'(sched_err), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
